pps_period_meter: RTL and testbench



---
 rtl/pps_period_meter.sv | 116 +++++++++++
 tb/tb_pps_period_meter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pps_period_meter.sv
// Measures clk cycles between consecutive PPS rising edges and reports the
// period, its signed error against NOMINAL, lock and loss-of-reference status.
module pps_period_meter #(
  parameter int CNT_W   = 32,
  parameter int NOMINAL = 21477270,
  parameter int TOL     = 2000,
  parameter int LOCK_N  = 4,
  parameter int TIMEOUT = 42954540
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pps,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] error,
  output logic             valid,
  output logic             locked,
  output logic             pps_lost
);

  // state   | meaning
  // IDLE    | unarmed; next edge starts a measurement, no result produced
  // MEASURE | counting; each edge yields a result, timeout drops to IDLE

  localparam int               GC_W    = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] NOM_V   = CNT_W'(NOMINAL);
  localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
  localparam logic [GC_W-1:0]  GC_MAX  = GC_W'(LOCK_N);

  typedef enum logic {IDLE, MEASURE} state_t;

  state_t           state, state_next;
  logic             s1, s2, d;
  logic             pps_edge;
  logic [CNT_W-1:0] cnt;
  logic             cnt_max;
  logic [CNT_W-1:0] meas, err, err_mag;
  logic             good;
  logic [GC_W-1:0]  gc, gc_next;
  logic             take, lose;

  assign pps_edge = s2 & ~d;
  assign cnt_max  = (cnt == CNT_MAX);
  assign meas     = cnt + 1'b1;
  assign err      = meas - NOM_V;
  assign err_mag  = err[CNT_W-1] ? (~err + 1'b1) : err;
  assign good     = (err_mag <= TOL_V);
  assign gc_next  = !good ? '0 : ((gc == GC_MAX) ? gc : gc + 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      d  <= 1'b0;
    end else begin
      s1 <= pps;
      s2 <= s1;
      d  <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // An edge coinciding with the timeout count takes priority over the timeout.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    lose       = 1'b0;
    case (state)
      IDLE: begin
        if (pps_edge) state_next = MEASURE;
      end
      MEASURE: begin
        if (pps_edge) begin
          take = 1'b1;
        end else if (cnt_max) begin
          lose       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      period   <= '0;
      error    <= '0;
      valid    <= 1'b0;
      locked   <= 1'b0;
      pps_lost <= 1'b0;
      gc       <= '0;
    end else begin
      if (pps_edge)     cnt <= '0;
      else if (!cnt_max) cnt <= cnt + 1'b1;

      valid <= take;
      if (take) begin
        period   <= meas;
        error    <= err;
        gc       <= gc_next;
        locked   <= (gc_next == GC_MAX);
        pps_lost <= 1'b0;
      end else if (lose) begin
        gc       <= '0;
        locked   <= 1'b0;
        pps_lost <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pps_period_meter.sv
// Scoreboard bench for pps_period_meter: PPS edges are described by their
// spacing in clk cycles and a gap-level model predicts each result.
module tb_pps_period_meter;

  localparam int CNT_W   = 16;
  localparam int NOMINAL = 100;
  localparam int TOL     = 2;
  localparam int LOCK_N  = 3;
  localparam int TIMEOUT = 250;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pps = 1'b0;
  logic [CNT_W-1:0] period, error;
  logic             valid, locked, pps_lost;

  pps_period_meter #(
    .CNT_W(CNT_W), .NOMINAL(NOMINAL), .TOL(TOL), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pps(pps), .period(period), .error(error),
    .valid(valid), .locked(locked), .pps_lost(pps_lost)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] p;
    logic [15:0] e;
    logic        lk;
    logic        lost;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model state
  bit m_armed = 0;
  int m_gc    = 0;
  bit m_lk    = 0;
  bit m_lost  = 0;
  int since   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One PPS rising edge, gap cycles after the previous one.
  task automatic model_edge(input int gap);
    exp_t x;
    int   err;
    if (m_armed && gap > TIMEOUT) begin
      m_lost = 1; m_gc = 0; m_lk = 0;
    end else if (m_armed) begin
      err    = gap - NOMINAL;
      m_gc   = ((err <= TOL) && (err >= -TOL)) ? ((m_gc < LOCK_N) ? m_gc + 1 : LOCK_N) : 0;
      m_lk   = (m_gc == LOCK_N);
      m_lost = 0;
      x.p    = 16'(gap);
      x.e    = 16'(err);
      x.lk   = m_lk;
      x.lost = 1'b0;
      q.push_back(x);
    end
    m_armed = 1;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(negedge clk);
      since++;
    end
  endtask

  // pps high for 3 cycles; status is settled by then for this edge.
  task automatic pulse(input int gap);
    while (since < gap) idle_cycles(1);
    pps = 1'b1;
    model_edge(gap);
    since = 0;
    idle_cycles(3);
    chk("locked", {31'd0, locked}, {31'd0, m_lk});
    chk("pps_lost", {31'd0, pps_lost}, {31'd0, m_lost});
    pps = 1'b0;
  endtask

  task automatic model_reset();
    m_armed = 0; m_gc = 0; m_lk = 0; m_lost = 0;
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 period=%0d expected no valid at %0t", period, $time);
      end else begin
        e = q.pop_front();
        chk("period", {16'd0, period}, {16'd0, e.p});
        chk("error", {16'd0, error}, {16'd0, e.e});
        chk("valid_locked", {31'd0, locked}, {31'd0, e.lk});
        chk("valid_pps_lost", {31'd0, pps_lost}, {31'd0, e.lost});
      end
    end
  end

  initial begin
    int r;
    // reset held with pps toggling
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i % 3 == 0) pps = ~pps;
      #1;
      chk("reset_outputs", {13'd0, period, error, valid, locked, pps_lost}, 32'd0);
    end
    pps = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    since = 0;

    // arm, then nominal spacing to lock
    pulse(20);
    for (int i = 0; i < 5; i++) pulse(100);
    // off-nominal while locked
    pulse(103);
    pulse(98);
    // reference stops, re-arm, recover
    pulse(300);
    pulse(100);
    for (int i = 0; i < 3; i++) pulse(100);
    // timeout boundaries
    pulse(249);
    pulse(250);
    pulse(251);
    pulse(100);

    // randomized spacing
    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 7)       pulse(int'($urandom_range(96, 104)));
      else if (r == 7) pulse(int'($urandom_range(245, 258)));
      else             pulse(int'($urandom_range(5, 30)));
    end

    // reset pulsed 50 cycles into a locked run
    for (int i = 0; i < 4; i++) pulse(100);
    chk("locked_before_reset", {31'd0, locked}, 32'd1);
    while (since < 50) idle_cycles(1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {13'd0, period, error, valid, locked, pps_lost}, 32'd0);
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    since = 0;
    for (int i = 0; i < 4; i++) pulse(100);
    chk("relock_after_reset", {31'd0, locked}, 32'd1);

    idle_cycles(10);
    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
